bcd_updown_counter: RTL and testbench



---
 rtl/bcd_updown_counter.sv | 89 ++++++++
 tb/tb_bcd_updown_counter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load and registered terminal-count pulse.
// Optional macro BCD_COUNTER_2421_EN adds a w2421 output carrying the 2421 code of each q digit.
module bcd_updown_counter #(
   parameter int unsigned DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_COUNTER_2421_EN
   output logic [4*DIGITS-1:0]   w2421,
`endif
   output logic [4*DIGITS-1:0]   q,
   output logic                  tc
);

   localparam int unsigned W = 4 * DIGITS;

   logic [W-1:0] q_q, q_d;
   logic         tc_q, tc_d;

   // Next state: load sanitises nibbles, count ripples carry/borrow through all digits in one cycle.
   always_comb begin
      logic       carry;
      logic [3:0] dig;
      q_d   = q_q;
      tc_d  = 1'b0;
      carry = 1'b0;
      dig   = 4'd0;
      if (load) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            dig = load_val[4*i +: 4];
            q_d[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
         end
      end else if (en) begin
         carry = 1'b1;
         for (int i = 0; i < int'(DIGITS); i++) begin
            dig = q_q[4*i +: 4];
            if (carry) begin
               if (up) begin
                  if (dig >= 4'd9) begin
                     q_d[4*i +: 4] = 4'd0;
                  end else begin
                     q_d[4*i +: 4] = 4'(dig + 4'd1);
                     carry         = 1'b0;
                  end
               end else begin
                  if (dig == 4'd0) begin
                     q_d[4*i +: 4] = 4'd9;
                  end else begin
                     q_d[4*i +: 4] = 4'(dig - 4'd1);
                     carry         = 1'b0;
                  end
               end
            end
         end
         tc_d = carry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q  <= '0;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
      end
   end

   assign q  = q_q;
   assign tc = tc_q;

`ifdef BCD_COUNTER_2421_EN
   // 2421 code: digits 5-9 are offset by 6 so the top bit carries weight 2.
   always_comb begin
      logic [3:0] d;
      d     = 4'd0;
      w2421 = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         d = q_q[4*i +: 4];
         w2421[4*i +: 4] = (d < 4'd5) ? d : 4'(d + 4'd6);
      end
   end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (DIGITS=2): integer reference model feeds a scoreboard queue.
module tb_bcd_updown_counter;

   localparam int unsigned DIGITS = 2;
   localparam int unsigned W      = 4 * DIGITS;
   localparam int          MODV   = 100;

   logic          clk = 1'b0;
   logic          rst, en, up, load;
   logic [W-1:0]  load_val;
   logic [W-1:0]  q;
   logic          tc;
`ifdef BCD_COUNTER_2421_EN
   logic [W-1:0]  w2421;
`endif

   int            checks = 0;
   int            errors = 0;
   int            m_val  = 0;
   logic          m_tc   = 1'b0;
   logic [W:0]    sb[$];

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
`ifdef BCD_COUNTER_2421_EN
      .w2421    (w2421),
`endif
      .q        (q),
      .tc       (tc)
   );

   function automatic logic [W-1:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int sanitise(input logic [W-1:0] v);
      int hi, lo;
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      if (hi > 9) hi = 0;
      if (lo > 9) lo = 0;
      return hi * 10 + lo;
   endfunction

   // Drive one cycle of inputs, advance the decimal model, queue the expectation, wait past the edge.
   task automatic apply(input logic r, input logic e, input logic u, input logic l,
                        input logic [W-1:0] v);
      rst = r; en = e; up = u; load = l; load_val = v;
      if (r) begin
         m_val = 0; m_tc = 1'b0;
      end else if (l) begin
         m_val = sanitise(v); m_tc = 1'b0;
      end else if (e) begin
         if (u) begin
            m_tc  = (m_val == MODV - 1);
            m_val = (m_val + 1) % MODV;
         end else begin
            m_tc  = (m_val == 0);
            m_val = (m_val + MODV - 1) % MODV;
         end
      end else begin
         m_tc = 1'b0;
      end
      sb.push_back({m_tc, to_bcd(m_val)});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [W:0] exp;
      apply(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
      exp = sb.pop_front();
      checks++;
      if ({tc, q} !== exp) begin
         errors++;
         $display("FAIL reset: tc,q=%0h,%02h expected %0h,%02h", tc, q, exp[W], exp[W-1:0]);
      end
      checks++;
      if ({tc, q} !== 9'h000) begin
         errors++;
         $display("FAIL reset_const: tc,q=%0h,%02h expected 0,00", tc, q);
      end
   endtask

   task automatic test_up_wrap();
      logic [W:0] exp;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h98);
         else        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
         exp = sb.pop_front();
         checks++;
         if ({tc, q} !== exp) begin
            errors++;
            $display("FAIL up_wrap[%0d]: tc,q=%0h,%02h expected %0h,%02h", i, tc, q, exp[W], exp[W-1:0]);
         end
      end
      checks++;
      if ({tc, q} !== 9'h100) begin
         errors++;
         $display("FAIL up_wrap_const: tc,q=%0h,%02h expected 1,00", tc, q);
      end
      apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      exp = sb.pop_front();
      checks++;
      if ({tc, q} !== exp) begin
         errors++;
         $display("FAIL up_wrap_tc_drop: tc,q=%0h,%02h expected %0h,%02h", tc, q, exp[W], exp[W-1:0]);
      end
   endtask

   task automatic test_down_wrap();
      logic [W:0] exp;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h01);
         else        apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         exp = sb.pop_front();
         checks++;
         if ({tc, q} !== exp) begin
            errors++;
            $display("FAIL down_wrap[%0d]: tc,q=%0h,%02h expected %0h,%02h", i, tc, q, exp[W], exp[W-1:0]);
         end
         if (i == 2) begin
            checks++;
            if ({tc, q} !== 9'h199) begin
               errors++;
               $display("FAIL down_wrap_const: tc,q=%0h,%02h expected 1,99", tc, q);
            end
         end
      end
   endtask

   task automatic test_load_priority();
      logic [W:0]   exp;
      logic [W-1:0] vals[3];
      vals[0] = 8'h3A; vals[1] = 8'hFF; vals[2] = 8'hB7;
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, 1'b1, 1'b1, vals[i]);
         exp = sb.pop_front();
         checks++;
         if ({tc, q} !== exp) begin
            errors++;
            $display("FAIL load[%0d]: tc,q=%0h,%02h expected %0h,%02h", i, tc, q, exp[W], exp[W-1:0]);
         end
      end
   endtask

   task automatic test_direction_change();
      logic [W:0] exp;
      apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
      exp = sb.pop_front();
      for (int i = 0; i < 12; i++) begin
         apply(1'b0, 1'b1, logic'($urandom_range(0, 1)), 1'b0, 8'h00);
         exp = sb.pop_front();
         checks++;
         if ({tc, q} !== exp) begin
            errors++;
            $display("FAIL dir_change[%0d]: tc,q=%0h,%02h expected %0h,%02h", i, tc, q, exp[W], exp[W-1:0]);
         end
      end
   endtask

   task automatic test_hold_reset();
      logic [W:0] exp;
      apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      exp = sb.pop_front();
      for (int i = 0; i < 57; i++) begin
         apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
         exp = sb.pop_front();
         checks++;
         if ({tc, q} !== exp) begin
            errors++;
            $display("FAIL count57[%0d]: tc,q=%0h,%02h expected %0h,%02h", i, tc, q, exp[W], exp[W-1:0]);
         end
      end
      checks++;
      if (q !== 8'h57) begin
         errors++;
         $display("FAIL count57_const: q=%02h expected 57", q);
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, logic'(i % 2), 1'b0, 8'h00);
         exp = sb.pop_front();
         checks++;
         if ({tc, q} !== exp) begin
            errors++;
            $display("FAIL hold[%0d]: tc,q=%0h,%02h expected %0h,%02h", i, tc, q, exp[W], exp[W-1:0]);
         end
      end
      apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      exp = sb.pop_front();
      checks++;
      if ({tc, q} !== exp) begin
         errors++;
         $display("FAIL mid_reset: tc,q=%0h,%02h expected %0h,%02h", tc, q, exp[W], exp[W-1:0]);
      end
   endtask

   task automatic test_sweep();
      logic [W:0] exp;
      int         pulses = 0;
      int         pos[2];
      pos[0] = -1; pos[1] = -1000;
      for (int i = 0; i < 200; i++) begin
         apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
         exp = sb.pop_front();
         checks++;
         if ({tc, q} !== exp) begin
            errors++;
            $display("FAIL sweep[%0d]: tc,q=%0h,%02h expected %0h,%02h", i, tc, q, exp[W], exp[W-1:0]);
         end
         if (tc === 1'b1) begin
            if (pulses < 2) pos[pulses] = i;
            pulses++;
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL sweep_pulses: count=%0d expected 2", pulses);
      end
      checks++;
      if (pos[1] - pos[0] != 100) begin
         errors++;
         $display("FAIL sweep_spacing: spacing=%0d expected 100", pos[1] - pos[0]);
      end
   endtask

`ifdef BCD_COUNTER_2421_EN
   task automatic test_2421();
      logic [W:0]   exp;
      logic [W-1:0] ld[3];
      logic [W-1:0] code[3];
      ld[0] = 8'h58; code[0] = 8'hBE;
      ld[1] = 8'h09; code[1] = 8'h0F;
      ld[2] = 8'h40; code[2] = 8'h40;
      apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      exp = sb.pop_front();
      checks++;
      if (w2421 !== 8'h00) begin
         errors++;
         $display("FAIL w2421_reset: w2421=%02h expected 00", w2421);
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b1, ld[i]);
         exp = sb.pop_front();
         checks++;
         if ({tc, q} !== exp) begin
            errors++;
            $display("FAIL w2421_load[%0d]: tc,q=%0h,%02h expected %0h,%02h", i, tc, q, exp[W], exp[W-1:0]);
         end
         checks++;
         if (w2421 !== code[i]) begin
            errors++;
            $display("FAIL w2421[%0d]: w2421=%02h expected %02h", i, w2421, code[i]);
         end
      end
   endtask
`endif

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
      #2;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load_priority();
      test_direction_change();
      test_hold_reset();
      test_sweep();
`ifdef BCD_COUNTER_2421_EN
      test_2421();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
